seq_det_ctrl: RTL and testbench
===============================

Name: seq_det_ctrl

Overview:
Run-controller for a serial pattern detector. On a start request it latches a pattern and run limits, then samples the serial input on a divided-clock tick. It detects overlapping occurrences of the PAT_W-bit pattern and counts matches. The run ends on reaching a match target, on exhausting a sample window, or on abort. It is the sequencing and configuration block around the team's bit-serial detector FSMs.

Parameters:
PAT_W, 4, pattern length in bits (2..8)
DIV, 4, clocks per sample tick (1 = sample every clock)
CNT_W, 8, width of match counter and match target

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  synchronous, active-high; forces IDLE and clears all state
start  in  1  run request; honoured only in IDLE
abort  in  1  cancel run; returns to IDLE from any non-IDLE state
in  in  1  serial data bit, sampled only on tick cycles in RUN
cfg_pattern  in  PAT_W  target pattern, MSB = oldest bit; latched on accepted start
cfg_window  in  16  samples per run; 0 = unlimited; latched on start
cfg_limit  in  CNT_W  matches needed to finish; 0 = never finish on matches; latched on start
busy  out  1  high in ARM and RUN
match  out  1  one-clock pulse per detected match
match_cnt  out  CNT_W  matches this run, saturating at all-ones
done  out  1  one-clock pulse in DONE
hit  out  1  last run ended on reaching cfg_limit
timeout  out  1  last run ended on exhausting cfg_window
state  out  2  IDLE=0, ARM=1, RUN=2, DONE=3

Behaviour:
- Reset: state=IDLE; all outputs 0; shift register, fill count, sample count and divider cleared.
- IDLE: on start=1, latch the cfg_* inputs, clear the shift register, fill count, sample count, match_cnt, hit and timeout, then go to ARM. Without start, stay in IDLE; hit, timeout and match_cnt hold their values.
- ARM: lasts one cycle; divider cleared to 0; go to RUN.
- RUN: divider counts 0..DIV-1 and wraps; tick = (divider == DIV-1). The first tick therefore occurs DIV clocks after entering RUN.
- On each tick:
  - shift in into the LSB of the PAT_W shift register;
  - fill count increments, saturating at PAT_W;
  - sample count increments.
  - Match condition: fill count (including this bit) == PAT_W and new shift value == pattern.
- Match output is registered: match pulses and match_cnt updates in the clock after the tick.
- Detection is overlapping: the shift register is not cleared on a match. No match is possible before PAT_W samples, even if the pattern is all zeros.
- Termination is evaluated on the tick:
  - if the match takes the updated match_cnt to cfg_limit (cfg_limit != 0), hit=1 and the next state is DONE;
  - else if the updated sample count == cfg_window (cfg_window != 0), timeout=1 and the next state is DONE.
  - If both occur on the same tick, hit wins and timeout stays 0.
- DONE: done=1 for one cycle, then IDLE. hit and timeout are set on entry to DONE and held until the next accepted start.
- abort=1 in ARM, RUN or DONE: next state IDLE; no done pulse; hit=timeout=0; match_cnt holds.
- abort has priority over any termination on the same cycle. In IDLE, abort is ignored and start still applies.
- start is ignored while busy or in DONE.
- cfg_limit=0 with cfg_window=0: the run continues until abort.
- Sample count is 16-bit and does not wrap within a bounded window. With unlimited window it may wrap; wrap has no effect.
- match_cnt saturates at 2^CNT_W-1. Matches beyond that still pulse match.

Optional Feature:
SEQ_DET_MASK_EN: when defined, adds input cfg_mask[PAT_W-1:0], latched on start. Pattern bits with mask 0 are don't-care, so the compare is ((shift ^ pattern) & mask) == 0. A mask of all zeros matches every tick once fill reaches PAT_W. When undefined, the port is absent and the compare is exact equality.

Test Plan:
1. DIV=1, pattern=1011, limit=2, window=0; feed in=1,0,1,1,0,1,1 → match pulses after samples 4 and 7 (overlap), match_cnt=2, hit=1, timeout=0, done one cycle later, then state=0.
2. DIV=1, pattern=0000, limit=1; feed zeros → no match on samples 1–3, first match after sample 4, hit=1.
3. DIV=1, pattern=1011, limit=3, window=6; feed all zeros → done after 6th sample, timeout=1, hit=0, match_cnt=0.
4. DIV=1, pattern=1011, limit=1, window=4; feed 1,0,1,1 → match and window end on the same tick → hit=1, timeout=0.
5. DIV=4; toggle in every clock and hold the intended bit only on tick cycles (4th RUN clock, 8th, …) → shift register reflects tick samples only; pattern 1011 detected after 16 RUN clocks.
6. Mid-run: assert abort in RUN after 2 matches → IDLE next clock, no done, match_cnt=2. Then start during RUN of the next run → ignored. Then reset mid-RUN → all outputs 0, state=0.

Source files
------------

// File: rtl/seq_det_ctrl.sv
// Run controller for an overlapping serial pattern detector with match/window/abort termination.
// Optional per-bit don't-care mask on the compare is enabled by defining SEQ_DET_MASK_EN.
module seq_det_ctrl #(
  parameter int PAT_W = 4,
  parameter int DIV   = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic             in,
  input  logic [PAT_W-1:0] cfg_pattern,
  input  logic [15:0]      cfg_window,
  input  logic [CNT_W-1:0] cfg_limit,
`ifdef SEQ_DET_MASK_EN
  input  logic [PAT_W-1:0] cfg_mask,
`endif
  output logic             busy,
  output logic             match,
  output logic [CNT_W-1:0] match_cnt,
  output logic             done,
  output logic             hit,
  output logic             timeout,
  output logic [1:0]       state
);

  localparam int DIV_W  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int FILL_W = $clog2(PAT_W + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t             st_q;
  logic [PAT_W-1:0]   pat_q;
  logic [15:0]        win_q;
  logic [CNT_W-1:0]   lim_q;
`ifdef SEQ_DET_MASK_EN
  logic [PAT_W-1:0]   mask_q;
`endif
  logic [PAT_W-1:0]   shift_q;
  logic [FILL_W-1:0]  fill_q;
  logic [15:0]        scount_q;
  logic [DIV_W-1:0]   div_q;

  logic               tick;
  logic [PAT_W-1:0]   shift_nx;
  logic [FILL_W-1:0]  fill_nx;
  logic [15:0]        scount_nx;
  logic [CNT_W-1:0]   cnt_nx;
  logic               cmp_ok;
  logic               match_now;
  logic               lim_end;
  logic               win_end;

  assign state = st_q;

  // Next-sample view: everything below reflects the bit being shifted in on this tick.
  always_comb begin
    tick      = (div_q == DIV_W'(DIV - 1));
    shift_nx  = {shift_q[PAT_W-2:0], in};
    fill_nx   = (fill_q == FILL_W'(PAT_W)) ? fill_q : fill_q + 1'b1;
    scount_nx = scount_q + 16'd1;
    cnt_nx    = (&match_cnt) ? match_cnt : match_cnt + 1'b1;
`ifdef SEQ_DET_MASK_EN
    cmp_ok    = (((shift_nx ^ pat_q) & mask_q) == '0);
`else
    cmp_ok    = (shift_nx == pat_q);
`endif
    match_now = tick && (fill_nx == FILL_W'(PAT_W)) && cmp_ok;
    lim_end   = match_now && (lim_q != '0) && (cnt_nx == lim_q);
    win_end   = (win_q != '0) && (scount_nx == win_q);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      st_q      <= IDLE;
      pat_q     <= '0;
      win_q     <= '0;
      lim_q     <= '0;
`ifdef SEQ_DET_MASK_EN
      mask_q    <= '0;
`endif
      shift_q   <= '0;
      fill_q    <= '0;
      scount_q  <= '0;
      div_q     <= '0;
      busy      <= 1'b0;
      match     <= 1'b0;
      match_cnt <= '0;
      done      <= 1'b0;
      hit       <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      match <= 1'b0;
      done  <= 1'b0;
      if (abort && st_q != IDLE) begin
        st_q    <= IDLE;
        busy    <= 1'b0;
        hit     <= 1'b0;
        timeout <= 1'b0;
      end else begin
        case (st_q)
          IDLE: begin
            if (start) begin
              pat_q     <= cfg_pattern;
              win_q     <= cfg_window;
              lim_q     <= cfg_limit;
`ifdef SEQ_DET_MASK_EN
              mask_q    <= cfg_mask;
`endif
              shift_q   <= '0;
              fill_q    <= '0;
              scount_q  <= '0;
              match_cnt <= '0;
              hit       <= 1'b0;
              timeout   <= 1'b0;
              busy      <= 1'b1;
              st_q      <= ARM;
            end
          end
          ARM: begin
            div_q <= '0;
            st_q  <= RUN;
          end
          RUN: begin
            div_q <= tick ? '0 : div_q + 1'b1;
            if (tick) begin
              shift_q  <= shift_nx;
              fill_q   <= fill_nx;
              scount_q <= scount_nx;
              if (match_now) begin
                match     <= 1'b1;
                match_cnt <= cnt_nx;
              end
              // A limit hit takes precedence over a window end on the same tick.
              if (lim_end) begin
                hit  <= 1'b1;
                done <= 1'b1;
                busy <= 1'b0;
                st_q <= DONE;
              end else if (win_end) begin
                timeout <= 1'b1;
                done    <= 1'b1;
                busy    <= 1'b0;
                st_q    <= DONE;
              end
            end
          end
          DONE: begin
            st_q <= IDLE;
          end
          default: st_q <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_seq_det_ctrl.sv
// Directed bench for seq_det_ctrl: a DIV=1 instance checked against a scoreboarded reference
// model, plus a DIV=4 instance for tick-timing checks.
module tb_seq_det_ctrl;

  logic        clk = 1'b0;
  logic        reset, start, abort, in;
  logic [3:0]  cfg_pattern;
  logic [15:0] cfg_window;
  logic [7:0]  cfg_limit;
`ifdef SEQ_DET_MASK_EN
  logic [3:0]  cfg_mask = 4'hf;
`endif

  logic       busy1, match1, done1, hit1, to1;
  logic [7:0] cnt1;
  logic [1:0] st1;
  logic       busy4, match4, done4, hit4, to4;
  logic [7:0] cnt4;
  logic [1:0] st4;

  always #5 clk = ~clk;

  seq_det_ctrl #(.PAT_W(4), .DIV(1), .CNT_W(8)) u1 (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .in(in),
    .cfg_pattern(cfg_pattern), .cfg_window(cfg_window), .cfg_limit(cfg_limit),
`ifdef SEQ_DET_MASK_EN
    .cfg_mask(cfg_mask),
`endif
    .busy(busy1), .match(match1), .match_cnt(cnt1), .done(done1),
    .hit(hit1), .timeout(to1), .state(st1)
  );

  seq_det_ctrl #(.PAT_W(4), .DIV(4), .CNT_W(8)) u4 (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .in(in),
    .cfg_pattern(cfg_pattern), .cfg_window(cfg_window), .cfg_limit(cfg_limit),
`ifdef SEQ_DET_MASK_EN
    .cfg_mask(cfg_mask),
`endif
    .busy(busy4), .match(match4), .match_cnt(cnt4), .done(done4),
    .hit(hit4), .timeout(to4), .state(st4)
  );

  int unsigned n_chk = 0;
  int unsigned n_pass = 0;

  // Reference model for the DIV=1 instance
  logic [3:0]  m_shift, m_pat;
  int          m_fill;
  logic [15:0] m_sc, m_win;
  logic [7:0]  m_cnt, m_lim;
  logic        m_hit, m_to;
  logic [31:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; start = 1'b0; abort = 1'b0; in = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic launch(input logic [3:0] p, input logic [15:0] w, input logic [7:0] l);
    @(negedge clk);
    cfg_pattern = p; cfg_window = w; cfg_limit = l; start = 1'b1;
    m_shift = 4'h0; m_fill = 0; m_sc = 16'h0; m_cnt = 8'h0;
    m_pat = p; m_win = w; m_lim = l; m_hit = 1'b0; m_to = 1'b0;
    exp_q.delete();
    @(posedge clk); #1;
    chk("arm_state", 32'(st1), 32'd1);
    chk("arm_busy", 32'(busy1), 32'd1);
    chk("arm_cnt_clr", 32'(cnt1), 32'd0);
    @(negedge clk);
    start = 1'b0;
    @(posedge clk); #1;
    chk("run_state", 32'(st1), 32'd2);
  endtask

  task automatic tick1(input logic b);
    logic fin;
    fin = 1'b0;
    @(negedge clk);
    in = b;
    m_shift = {m_shift[2:0], b};
    if (m_fill < 4) m_fill++;
    m_sc = m_sc + 16'd1;
    if (m_fill == 4 && m_shift == m_pat) begin
      if (m_cnt != 8'hff) m_cnt = m_cnt + 8'd1;
      exp_q.push_back(32'(m_cnt));
      if (m_lim != 8'h0 && m_cnt == m_lim) begin
        m_hit = 1'b1;
        fin = 1'b1;
      end
    end
    if (!fin && m_win != 16'h0 && m_sc == m_win) begin
      m_to = 1'b1;
      fin = 1'b1;
    end
    @(posedge clk); #1;
    if (exp_q.size() != 0) begin
      chk("match_pulse", 32'(match1), 32'd1);
      chk("match_cnt", 32'(cnt1), exp_q.pop_front());
    end else begin
      chk("no_match", 32'(match1), 32'd0);
    end
    chk("run_or_done", 32'(st1), fin ? 32'd3 : 32'd2);
    if (fin) begin
      chk("done_pulse", 32'(done1), 32'd1);
      chk("hit_flag", 32'(hit1), 32'(m_hit));
      chk("timeout_flag", 32'(to1), 32'(m_to));
    end
  endtask

  task automatic feed(input logic [15:0] bits, input int n);
    logic [15:0] v;
    v = bits;
    for (int i = n - 1; i >= 0; i--) tick1(v[i]);
  endtask

  task automatic after_done();
    @(posedge clk); #1;
    chk("idle_after_done", 32'(st1), 32'd0);
    chk("done_one_cycle", 32'(done1), 32'd0);
    chk("hit_held", 32'(hit1), 32'(m_hit));
    chk("timeout_held", 32'(to1), 32'(m_to));
    chk("cnt_held", 32'(cnt1), 32'(m_cnt));
  endtask

  initial begin
    logic [3:0] seq5;
    logic       bit5;
    reset = 1'b1; start = 1'b0; abort = 1'b0; in = 1'b0;
    cfg_pattern = 4'h0; cfg_window = 16'h0; cfg_limit = 8'h0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_state", 32'(st1), 32'd0);
    chk("rst_outs", 32'({busy1, match1, done1, hit1, to1}), 32'd0);
    chk("rst_cnt", 32'(cnt1), 32'd0);
    chk("rst_state4", 32'(st4), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // 1: overlapping matches reach the limit
    launch(4'b1011, 16'd0, 8'd2);
    feed(16'b1011011, 7);
    after_done();

    // 2: all-zero pattern cannot match before four samples
    launch(4'b0000, 16'd0, 8'd1);
    feed(16'b0000, 4);
    after_done();

    // 3: window exhausted without matches
    launch(4'b1011, 16'd6, 8'd3);
    feed(16'b000000, 6);
    after_done();

    // 4: limit and window end on the same tick
    launch(4'b1011, 16'd4, 8'd1);
    feed(16'b1011, 4);
    after_done();

    // 5: DIV=4 samples only on every fourth RUN clock
    do_reset();
    launch(4'b1011, 16'd0, 8'd1);
    chk("div4_run", 32'(st4), 32'd2);
    seq5 = 4'b1011;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      bit5 = seq5[3 - (k - 1) / 4];
      in = (k % 4 == 0) ? bit5 : ~bit5;
      @(posedge clk); #1;
      chk("div4_match", 32'(match4), (k == 16) ? 32'd1 : 32'd0);
      chk("div4_state", 32'(st4), (k == 16) ? 32'd3 : 32'd2);
    end
    chk("div4_hit", 32'(hit4), 32'd1);
    chk("div4_cnt", 32'(cnt4), 32'd1);
    chk("div4_done", 32'(done4), 32'd1);

    // 6: abort mid-run, start ignored in RUN, reset mid-run
    do_reset();
    launch(4'b1011, 16'd0, 8'd0);
    feed(16'b1011011, 7);
    @(negedge clk);
    abort = 1'b1;
    @(posedge clk); #1;
    chk("abort_idle", 32'(st1), 32'd0);
    chk("abort_no_done", 32'(done1), 32'd0);
    chk("abort_cnt", 32'(cnt1), 32'd2);
    chk("abort_flags", 32'({busy1, hit1, to1}), 32'd0);
    @(negedge clk);
    abort = 1'b0;
    launch(4'b1011, 16'd0, 8'd0);
    tick1(1'b1);
    tick1(1'b0);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk); #1;
    chk("start_ignored", 32'(st1), 32'd2);
    chk("start_ign_busy", 32'(busy1), 32'd1);
    @(negedge clk);
    start = 1'b0;
    reset = 1'b1;
    @(posedge clk); #1;
    chk("midrun_rst_state", 32'(st1), 32'd0);
    chk("midrun_rst_outs", 32'({busy1, match1, done1, hit1, to1}), 32'd0);
    chk("midrun_rst_cnt", 32'(cnt1), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
